// File: rtl/uart_rx_register_if.sv
// Receive-side bus: serial line and consumer read strobe in, RBR contents and status out.
interface uart_rx_register_if;
  logic       Rx;
  logic       Read;
  logic [7:0] Data_out;
  logic       RBR_Valid;
  logic       Frame_Err;
  logic       Overrun;
  logic       Busy;

  modport master (output Rx, Read, input Data_out, RBR_Valid, Frame_Err, Overrun, Busy);
  modport slave  (input Rx, Read, output Data_out, RBR_Valid, Frame_Err, Overrun, Busy);
endinterface

// File: rtl/uart_rx_register.sv
// UART receiver: synchronizes Rx, samples 8N1 frames at mid-bit, and moves each frame RSR -> RBR.
module uart_rx_register #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_register_if.slave   bus
);
  localparam int HALF = CLKS_PER_BIT >> 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    rsr;
  logic          rx_meta, rx_s, rx_d;
  logic          load;

  // Load fires on the mid-stop sample, the same edge the FSM drops back to IDLE.
  assign load = (state == STOP) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bitn          <= '0;
      rsr           <= '0;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_d          <= 1'b1;
      bus.Data_out  <= '0;
      bus.RBR_Valid <= 1'b0;
      bus.Frame_Err <= 1'b0;
      bus.Overrun   <= 1'b0;
      bus.Busy      <= 1'b0;
    end else begin
      rx_meta <= bus.Rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;

      // A load in the same cycle as Read wins: valid stays set, overrun is left alone.
      if (load) begin
        bus.Data_out  <= rsr;
        bus.Frame_Err <= ~rx_s;
        bus.RBR_Valid <= 1'b1;
        if (bus.RBR_Valid && !bus.Read) bus.Overrun <= 1'b1;
      end else if (bus.Read) begin
        bus.RBR_Valid <= 1'b0;
        bus.Overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Only a falling edge arms the receiver, so a held-low break never retriggers.
          if (rx_d && !rx_s) begin
            state    <= START;
            cnt      <= '0;
            bus.Busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              bitn  <= '0;
            end else begin
              state    <= IDLE;
              bus.Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            rsr <= {rx_s, rsr[7:1]};
            if (bitn == 3'd7) state <= STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx_register.md
# uart_rx_register

Receive half of the UART: a self-timed receiver that synchronizes the serial `Rx` line, detects the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each completed frame is transferred from the receive shift register (RSR) into a receive buffer register (RBR), and `RBR_Valid` is raised. It is the counterpart of the transmit register block and sits between the board `Rx` pin and the core's I/O read port.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 4. `HALF = CLKS_PER_BIT >> 1`.
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `Rx`  in  1  asynchronous serial line; idles high
- `Read`  in  1  consumer pulse; clears `RBR_Valid` and `Overrun`
- `Data_out`  out  8  RBR contents
- `RBR_Valid`  out  1  RBR holds an unread byte
- `Frame_Err`  out  1  stop bit of the byte in RBR sampled 0
- `Overrun`  out  1  sticky: a byte was loaded while the previous one was unread
- `Busy`  out  1  FSM not in IDLE

## Operation
- **Input synchronizer:** 2-flop synchronizer on `Rx` produces `rx_s`, plus a delayed copy `rx_d`. All three reset to 1.
- **Start detection:** IDLE arms only on a falling edge (`rx_d`=1, `rx_s`=0). A line held low (break) therefore never retriggers.
- **FSM** (`cnt` is the bit-timing counter, `bitn` is a 3-bit index):
  - IDLE: on falling edge → START, `cnt`=0.
  - START: `cnt` increments each cycle. At `cnt`==HALF-1, sample `rx_s`.
    - If 0 → DATA, `cnt`=0, `bitn`=0.
    - If 1 → IDLE as a glitch: no load, no flags.
  - DATA: at `cnt`==CLKS_PER_BIT-1, do `RSR <= {rx_s, RSR[7:1]}` and set `cnt`=0. When `bitn`==7 → STOP; otherwise `bitn`++.
  - STOP: at `cnt`==CLKS_PER_BIT-1, perform the **load**, then → IDLE in the same edge.
- **Load:**
  - `RBR` ← RSR, `Frame_Err` ← ~`rx_s`, `RBR_Valid` ← 1.
  - `Overrun` ← 1 if `RBR_Valid`=1 and `Read`=0 in that cycle.
  - A frame with a bad stop bit is still loaded; only `Frame_Err` flags it.
- **Read:**
  - When no load occurs that cycle: `RBR_Valid` ← 0 and `Overrun` ← 0.
  - `Data_out` and `Frame_Err` hold their value.
  - `Read` while `RBR_Valid`=0 has no effect.
- **Load and Read in the same cycle:** load wins. `RBR_Valid` stays 1, `Overrun` is unchanged (cleared, not set), and `RBR` takes the new byte.
- `Busy` = (state ≠ IDLE).

## Timing
- **Reset:** state IDLE, `cnt`/`bitn`/RSR/RBR = 0. `Data_out`=0x00, `RBR_Valid`=0, `Frame_Err`=0, `Overrun`=0, `Busy`=0, sync flops = 1.
- Reset mid-frame aborts the frame with no load. Reset wins over every other event.
- **Edge numbering:** edge 0 is the first clock edge at which the first sync flop captures `Rx`=0.
  - START entered at edge 2 (`Busy` high after edge 2).
  - Start bit sampled at edge 2+HALF.
  - Data bit i sampled at edge 2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled and load performed at edge 2+HALF+9·CLKS_PER_BIT; `RBR_Valid` and `Data_out` update after that edge.
- Returning to IDLE at mid-stop allows back-to-back frames. The next start edge is accepted from the following cycle.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
1. **Single byte, CLKS_PER_BIT=16:** drive 0xA5 frame (start 0, bits 1,0,1,0,0,1,0,1, stop 1).
   - `RBR_Valid` rises after edge 154.
   - `Data_out`=0xA5, `Frame_Err`=0, `Overrun`=0.
   - `Read` pulse → `RBR_Valid`=0.
2. **Glitch reject:** `Rx` low for 4 cycles, then high.
   - START aborts at the HALF sample; `Busy` returns to 0.
   - No `RBR_Valid`; RSR/RBR unchanged.
3. **Framing error / break:** frame 0x3C with stop=0, then hold `Rx` low for 40 bit times.
   - One load: `Data_out`=0x3C, `Frame_Err`=1.
   - No further loads until `Rx` goes high and falls again.
4. **Overrun and collision:**
   - Receive 0x11 and 0x22 back-to-back without `Read` → `Data_out`=0x22, `Overrun`=1. `Read` clears both flags.
   - Repeat with `Read` asserted exactly on the second load cycle → `RBR_Valid`=1, `Overrun`=0, `Data_out`=0x22.
5. **Reset mid-frame:** assert `reset` for 1 cycle during DATA bit 4 of 0xFF.
   - All outputs return to reset values; no load occurs.
   - A subsequent 0x5A frame is received correctly.
6. **Baud tolerance:** transmitter bit period ±3% of `CLKS_PER_BIT`=16, 0x00 and 0xFF frames → both received with `Frame_Err`=0.
